// File: rtl/x25519_pkg.sv
// rtl/x25519_pkg.sv - field constants, limb layout and freeze FSM states for GF(2^255-19)
package x25519_pkg;

  localparam int LIMB_W = 8;
  localparam int LIMB_N = 32;
  localparam int TOP_W  = 16;
  localparam int VEC_W  = LIMB_W * (LIMB_N - 1) + TOP_W;

  typedef logic [VEC_W-1:0] limb_vec_t;

  // 2^256 - p = 2^255 + 19, split into limbs; limb 31 is the 16-bit top limb
  localparam logic [TOP_W-1:0] MINUS_P [LIMB_N] = '{0: 16'd19, 31: 16'd128, default: 16'd0};

  typedef enum logic [1:0] {IDLE, RUN, SEL} freeze_state_t;

endpackage

// File: rtl/x25519_limb_adder.sv
// rtl/x25519_limb_adder.sv - limb (or limb-pair) adder with a registered ripple carry
module x25519_limb_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         step,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum,
  output logic         carry
);

  assign sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (step) begin
      carry <= sum[W];
    end
  end

endmodule

// File: rtl/x25519_freeze.sv
// rtl/x25519_freeze.sv - constant-time canonical reduction mod 2^255-19, limb serial
// X25519_FREEZE_WIDE_EN: process two limbs per cycle (16-cycle RUN instead of 32).
module x25519_freeze
  import x25519_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  limb_vec_t    din,
  output logic         busy,
  output logic         out_valid,
  output logic [255:0] out
);

`ifdef X25519_FREEZE_WIDE_EN
  localparam int         AW   = 2 * LIMB_W;
  localparam logic [4:0] LAST = 5'd15;
`else
  localparam int         AW   = LIMB_W;
  localparam logic [4:0] LAST = 5'd31;
`endif

  freeze_state_t state, next_state;
  logic [4:0]    cnt;
  limb_vec_t     orig;
  logic [247:0]  work;
  logic [16:0]   work_top;
  logic [16:0]   top_sum;
  logic [255:0]  out_q, work_val, sel_mask, sel_val;
  logic [AW-1:0] add_a, add_b;
  logic [AW:0]   add_sum;
  logic          add_carry, top_cin, last, neg, unused_bits;

  assign last = (cnt == LAST);

`ifdef X25519_FREEZE_WIDE_EN
  // The final pair holds only limb 30 in the adder; limb 31 gets the wide top add.
  always_comb begin
    add_a = orig[16*cnt +: 16];
    add_b = {MINUS_P[{cnt[3:0], 1'b1}][7:0], MINUS_P[{cnt[3:0], 1'b0}][7:0]};
    if (last) begin
      add_a = {8'h00, orig[247:240]};
      add_b = {8'h00, MINUS_P[LIMB_N-2][7:0]};
    end
  end
  assign top_cin     = add_sum[LIMB_W];
  assign unused_bits = ^{add_carry, add_sum[AW]};
`else
  assign add_a       = orig[8*cnt +: 8];
  assign add_b       = MINUS_P[cnt][7:0];
  assign top_cin     = add_carry;
  assign unused_bits = add_sum[AW];
`endif

  assign top_sum = {1'b0, orig[263:248]} + {1'b0, MINUS_P[LIMB_N-1]} + {16'd0, top_cin};

  x25519_limb_adder #(.W(AW)) u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (en),
    .step  (state == RUN),
    .a     (add_a),
    .b     (add_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      orig     <= '0;
      work     <= '0;
      work_top <= '0;
    end else if (en) begin
      cnt      <= '0;
      orig     <= din;
      work     <= din[247:0];
      work_top <= {1'b0, din[263:248]};
    end else if (state == RUN) begin
      cnt <= cnt + 5'd1;
      if (last) begin
        work_top <= top_sum;
`ifdef X25519_FREEZE_WIDE_EN
        work[247:240] <= add_sum[7:0];
`endif
      end else begin
        work[AW*cnt +: AW] <= add_sum[AW-1:0];
      end
    end
  end

  // Bit 7 of the top limb set means no wrap past 2^256, i.e. din < p: keep orig.
  assign neg      = work_top[7];
  assign work_val = {work_top[7:0], work};
  assign sel_mask = {256{neg}};
  assign sel_val  = work_val ^ ((work_val ^ orig[255:0]) & sel_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (state == SEL) begin
      out_q <= sel_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = IDLE;
      RUN:     next_state = last ? SEL : RUN;
      SEL:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (en) begin
      next_state = RUN;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == SEL);
    out       = out_valid ? sel_val : out_q;
  end

endmodule

// File: tb/tb_x25519_freeze.sv
// tb/tb_x25519_freeze.sv - directed and random checks of x25519_freeze (narrow or X25519_FREEZE_WIDE_EN)
module tb_x25519_freeze;

`ifdef X25519_FREEZE_WIDE_EN
  localparam int LAT   = 17;
  localparam int RST_C = 10;
`else
  localparam int LAT   = 33;
  localparam int RST_C = 20;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [263:0] din = '0;
  logic         busy, out_valid;
  logic [255:0] out;

  int n_chk = 0;
  int n_fail = 0;

  x25519_freeze dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [263:0] din;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs[10];

  logic [263:0] p_val;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] ref_mod(input logic [263:0] x);
    logic [263:0] t;
    t = (x >= p_val) ? x - p_val : x;
    return t[255:0];
  endfunction

  // Start with d1; optionally re-pulse en with d2 at cycle re_c, reset at rst_c,
  // and sample busy/out at cycle obs_c. Cycle i is the i-th cycle after the en cycle.
  task automatic run_seq(input logic [263:0] d1, input int re_c, input logic [263:0] d2,
                         input int rst_c, input int obs_c, input int maxc,
                         output int np, output int c1, output logic [255:0] o1,
                         output int c2, output logic [255:0] o2,
                         output logic obs_busy, output logic [255:0] obs_out);
    np = 0; c1 = -1; c2 = -1; o1 = '0; o2 = '0; obs_busy = 1'bx; obs_out = 'x;
    @(negedge clk);
    din = d1;
    en  = 1'b1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      en = 1'b0;
      if (out_valid) begin
        np++;
        if (np == 1) begin c1 = i; o1 = out; end
        else if (np == 2) begin c2 = i; o2 = out; end
      end
      if (i == obs_c) begin obs_busy = busy; obs_out = out; end
      if (i == re_c) begin din = d2; en = 1'b1; end
      rst_n = (i != rst_c);
    end
  endtask

  initial begin
    int np, c1, c2;
    logic [255:0] o1, o2, ob_out;
    logic ob_busy;
    logic [263:0] x, pm1, pp5;

    p_val = {16'h007F, {30{8'hFF}}, 8'hED};
    pm1   = p_val - 264'd1;
    pp5   = p_val + 264'd5;

    vecs[0] = '{"p",          p_val,                                  256'd0};
    vecs[1] = '{"p_minus_1",  pm1,                                    pm1[255:0]};
    vecs[2] = '{"p_plus_5",   pp5,                                    256'd5};
    vecs[3] = '{"2^255-1",    {16'h007F, {31{8'hFF}}},                256'd18};
    vecs[4] = '{"zero",       264'd0,                                 256'd0};
    vecs[5] = '{"one",        264'd1,                                 256'd1};
    vecs[6] = '{"2p-1",       {16'h00FF, {30{8'hFF}}, 8'hD9},         pm1[255:0]};
    vecs[7] = '{"2^255",      {16'h0080, 248'd0},                     256'd19};
    vecs[8] = '{"2^255+2^100", {16'h0080, 248'd0} | (264'd1 << 100),  (256'd1 << 100) | 256'd19};
    vecs[9] = '{"p_plus_2^200", p_val + (264'd1 << 200),              256'd1 << 200};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      {255'd0, busy},      256'd0);
    chk("reset_out_valid", {255'd0, out_valid}, 256'd0);
    chk("reset_out",       out,                 256'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      run_seq(vecs[k].din, -1, '0, -1, LAT + 1, LAT + 4, np, c1, o1, c2, o2, ob_busy, ob_out);
      chk({vecs[k].name, "_pulses"},  256'(np), 256'd1);
      chk({vecs[k].name, "_latency"}, 256'(c1), 256'(LAT));
      chk({vecs[k].name, "_out"},     o1,       vecs[k].exp);
      chk({vecs[k].name, "_idle"},    {255'd0, ob_busy}, 256'd0);
      chk({vecs[k].name, "_hold"},    ob_out,   vecs[k].exp);
    end

    run_seq(pp5, -1, '0, -1, 1, LAT + 2, np, c1, o1, c2, o2, ob_busy, ob_out);
    chk("busy_first_cycle", {255'd0, ob_busy}, 256'd1);

    // restart mid-operation
    run_seq(pp5, 10, 264'd7, -1, -1, 10 + LAT + 6, np, c1, o1, c2, o2, ob_busy, ob_out);
    chk("abort_pulses",  256'(np), 256'd1);
    chk("abort_latency", 256'(c1), 256'(10 + LAT));
    chk("abort_out",     o1,       256'd7);

    // reset mid-operation
    run_seq(pp5, -1, '0, RST_C, RST_C + 1, LAT + 10, np, c1, o1, c2, o2, ob_busy, ob_out);
    chk("rst_pulses", 256'(np), 256'd0);
    chk("rst_busy",   {255'd0, ob_busy}, 256'd0);
    chk("rst_out",    ob_out,   256'd0);
    run_seq(pm1, -1, '0, -1, -1, LAT + 3, np, c1, o1, c2, o2, ob_busy, ob_out);
    chk("post_rst_latency", 256'(c1), 256'(LAT));
    chk("post_rst_out",     o1,       pm1[255:0]);

    // en during SEL: the finishing result still fires, then the new one follows
    run_seq(pm1, LAT, pp5, -1, LAT + 5, 2 * LAT + 4, np, c1, o1, c2, o2, ob_busy, ob_out);
    chk("sel_en_pulses",    256'(np), 256'd2);
    chk("sel_en_latency1",  256'(c1), 256'(LAT));
    chk("sel_en_out1",      o1,       pm1[255:0]);
    chk("sel_en_latency2",  256'(c2), 256'(2 * LAT));
    chk("sel_en_out2",      o2,       256'd5);
    chk("sel_en_busy",      {255'd0, ob_busy}, 256'd1);
    chk("sel_en_hold",      ob_out,   pm1[255:0]);

    for (int r = 0; r < 1000; r++) begin
      if (r % 4 == 0) begin
        x = p_val - 264'd40 + 264'($urandom_range(0, 80));
      end else if (r % 4 == 1) begin
        x = 2 * p_val - 264'd1 - 264'($urandom_range(0, 40));
      end else begin
        x = 2 * p_val;
        while (x >= 2 * p_val) begin
          x = {8'h00, $urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
      run_seq(x, -1, '0, -1, -1, LAT + 1, np, c1, o1, c2, o2, ob_busy, ob_out);
      chk("rand_latency", 256'(c1), 256'(LAT));
      chk("rand_out",     o1,       ref_mod(x));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
